eth_transmitter_system: RTL

Memory-mapped Ethernet transmit path: the CPU fills a 2 KiB frame buffer over the system bus, programs the frame length, and writes a start command. The block then acts as SPI master and streams the frame MSB-first to the external MAC/PHY controller, reporting busy/done status through a CPU-readable register. It sits on the same CPU bus as the receive system and uses disjoint addresses.

---
 rtl/eth_tx_pkg.sv | 31 +++
 rtl/eth_transmitter_spi.sv | 157 +++++++++++++++
 rtl/eth_transmitter_system.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/eth_tx_pkg.sv
// Shared constants and types for the Ethernet transmit path.
package eth_tx_pkg;

  // Buffer window 0xE800-0xEFFF: an address hits when (a & BufMask) == BufBase.
  localparam logic [15:0] BufBase   = 16'hE800;
  localparam logic [15:0] BufMask   = 16'hF800;
  localparam logic [15:0] CtrlAddr  = 16'hFC00;
  localparam logic [15:0] LenLoAddr = 16'hFC02;
  localparam logic [15:0] LenHiAddr = 16'hFC03;

  localparam int unsigned BufAw    = 11;
  localparam int unsigned BufDepth = 2048;

  // CTRL write bits and STATUS read bits.
  localparam int unsigned CtrlStartBit = 0;
  localparam int unsigned CtrlAbortBit = 1;
  localparam int unsigned StatBusyBit  = 0;
  localparam int unsigned StatDoneBit  = 1;

  typedef enum logic [1:0] {
    StIdle,
    StSelect,
    StShift,
    StDeselect
  } tx_state_e;

  function automatic logic is_buf_addr(input logic [15:0] addr);
    return (addr & BufMask) == BufBase;
  endfunction

endpackage

// File: rtl/eth_transmitter_spi.sv
// SPI master engine: FSM, clock divider, bit/byte counters and shift register.
// Streams bytes 0..len-1 from the frame buffer MSB-first, SPI mode 0.
module eth_transmitter_spi
  import eth_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             abort,
  input  logic [BufAw-1:0] len,
  output logic [BufAw-1:0] rd_addr,
  input  logic [7:0]       rd_data,
  output logic             tx_sck,
  output logic             tx_mosi,
  output logic             n_tx_ss,
  output logic             done
);

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

  tx_state_e        state_q, state_d;
  logic [7:0]       div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [BufAw-1:0] idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       next_q, next_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             ss_q, ss_d;
  logic             div_end;

  assign div_end = (div_q == DivLast);

  // While shifting, look one byte ahead; in SELECT idx is 0 so byte 0 is fetched.
  // idx never exceeds len-1 <= 2046, so idx+1 cannot wrap.
  assign rd_addr = (state_q == StShift) ? idx_q + 11'd1 : idx_q;

  assign tx_sck  = sck_q;
  assign tx_mosi = mosi_q;
  assign n_tx_ss = ss_q;

  // State register; reset is synchronous and active-high on n_rst.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      next_q  <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      ss_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      next_q  <= next_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      ss_q    <= ss_d;
    end
  end

  // Next-state logic; sck_q doubles as the low/high phase of the current bit.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    next_d  = next_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    ss_d    = ss_q;
    done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSelect;
          ss_d    = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          idx_d   = '0;
        end
      end

      StSelect: begin
        if (div_end) begin
          div_d   = '0;
          state_d = StShift;
          shift_d = rd_data;
          mosi_d  = rd_data[7];
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      StShift: begin
        next_d = rd_data;
        if (!div_end) begin
          div_d = div_q + 8'd1;
        end else begin
          div_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d = 1'b0;
            if (bit_q != 3'd7) begin
              bit_d   = bit_q + 3'd1;
              shift_d = {shift_q[6:0], 1'b0};
              mosi_d  = shift_q[6];
            end else if (idx_q == len - 11'd1) begin
              state_d = StDeselect;
            end else begin
              // Back-to-back: the prefetched byte goes out with no gap.
              bit_d   = '0;
              idx_d   = idx_q + 11'd1;
              shift_d = next_q;
              mosi_d  = next_q[7];
            end
          end
        end
      end

      StDeselect: begin
        if (div_end) begin
          div_d   = '0;
          state_d = StIdle;
          ss_d    = 1'b1;
          mosi_d  = 1'b0;
          done    = 1'b1;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      default: state_d = StIdle;
    endcase

    // Abort overrides everything and leaves DONE untouched.
    if (abort) begin
      state_d = StIdle;
      div_d   = '0;
      sck_d   = 1'b0;
      mosi_d  = 1'b0;
      ss_d    = 1'b1;
      done    = 1'b0;
    end
  end

endmodule

// File: rtl/eth_transmitter_system.sv
// CPU-facing transmit block: frame buffer, register file, address decode and
// the bidirectional data bus. The SPI engine lives in eth_transmitter_spi.
module eth_transmitter_system
  import eth_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [15:0] a,
  inout  wire  [7:0]  d,
  input  logic        n_we,
  input  logic        n_oe,
  output logic        tx_sck,
  output logic        tx_mosi,
  output logic        n_tx_ss,
  output logic        n_rdy
);

  logic [7:0]       buf_mem [BufDepth];

  logic             n_we_q;
  logic             commit;
  logic             buf_we;
  logic             ctrl_wr;
  logic             len_lo_we;
  logic             len_hi_we;
  logic             start_cmd;
  logic             abort_cmd;

  logic [7:0]       len_lo_q;
  logic [2:0]       len_hi_q;
  logic [BufAw-1:0] len_cur;
  logic [BufAw-1:0] len_lat_q;
  logic             busy_q;
  logic             done_q;
  logic             start_q;
  logic             abort_q;

  logic [BufAw-1:0] tx_rd_addr;
  logic [7:0]       tx_rd_data;
  logic             tx_done;

  logic             rd_hit;
  logic [7:0]       rd_val;

  assign n_rdy   = 1'b0;
  assign len_cur = {len_hi_q, len_lo_q};

  // One write per n_we assertion: commit on the first edge n_we is seen low.
  assign commit    = n_we_q && !n_we && !n_rst;
  assign ctrl_wr   = commit && (a == CtrlAddr);
  assign buf_we    = commit && is_buf_addr(a) && !busy_q;
  assign len_lo_we = commit && (a == LenLoAddr) && !busy_q;
  assign len_hi_we = commit && (a == LenHiAddr) && !busy_q;
  // ABORT wins over START when both are set in one write.
  assign start_cmd = ctrl_wr && d[CtrlStartBit] && !d[CtrlAbortBit] && !busy_q &&
                     (len_cur != '0);
  assign abort_cmd = ctrl_wr && d[CtrlAbortBit] && busy_q;

  // Registered copy of the write strobe for edge detection.
  always_ff @(posedge clk) begin
    if (n_rst) n_we_q <= 1'b1;
    else       n_we_q <= n_we;
  end

  // Frame buffer write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[a[BufAw-1:0]] <= d;
  end

  assign tx_rd_data = buf_mem[tx_rd_addr];

  // Length, status and command registers.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      len_lo_q  <= '0;
      len_hi_q  <= '0;
      len_lat_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      start_q <= start_cmd;
      abort_q <= abort_cmd;
      if (len_lo_we) len_lo_q <= d;
      if (len_hi_we) len_hi_q <= d[2:0];
      if (start_cmd) begin
        len_lat_q <= len_cur;
        busy_q    <= 1'b1;
        done_q    <= 1'b0;
      end else if (abort_q) begin
        busy_q <= 1'b0;
      end else if (tx_done) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  // Read decode; the buffer read port is always available.
  always_comb begin
    rd_hit = 1'b0;
    rd_val = '0;
    if (is_buf_addr(a)) begin
      rd_hit = 1'b1;
      rd_val = buf_mem[a[BufAw-1:0]];
    end else if (a == CtrlAddr) begin
      rd_hit              = 1'b1;
      rd_val[StatBusyBit] = busy_q;
      rd_val[StatDoneBit] = done_q;
    end else if (a == LenLoAddr) begin
      rd_hit = 1'b1;
      rd_val = len_lo_q;
    end else if (a == LenHiAddr) begin
      rd_hit = 1'b1;
      rd_val = {5'b0, len_hi_q};
    end
  end

  assign d = (rd_hit && !n_oe) ? rd_val : 8'bz;

  eth_transmitter_spi #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (start_q),
    .abort   (abort_q),
    .len     (len_lat_q),
    .rd_addr (tx_rd_addr),
    .rd_data (tx_rd_data),
    .tx_sck  (tx_sck),
    .tx_mosi (tx_mosi),
    .n_tx_ss (n_tx_ss),
    .done    (tx_done)
  );

endmodule
